// File: rtl/lzma2_rc_carry_resolver.sv
// Resolves the range encoder's delayed carries: keeps one cached byte plus a run of
// pending 0xFF bytes, and emits final bytes on a valid/ready stream, draining everything on flush.
module lzma2_rc_carry_resolver #(
    parameter int PEND_W           = 16,
    parameter bit INIT_CACHE_VALID = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_carry,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        flush_done,
    output logic [31:0] bytes_out,
    output logic        run_overflow
);

    typedef enum logic [2:0] {
        IDLE, EMIT_CACHE, EMIT_RUN, FLUSH_CACHE, FLUSH_RUN, DONE
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

    // The cache can never hold 0xFF, so adding the carry never wraps.
    function automatic logic [7:0] add_carry(input logic [7:0] cache, input logic carry);
        return cache + {7'd0, carry};
    endfunction

    // A carry turns every pending 0xFF into 0x00.
    function automatic logic [7:0] run_byte(input logic carry);
        return carry ? 8'h00 : 8'hFF;
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         cache_q, cache_d;
    logic               have_cache_q, have_cache_d;
    logic [PEND_W-1:0]  pend_cnt_q, pend_cnt_d;
    logic               carry_q, carry_d;
    logic [7:0]         next_cache_q, next_cache_d;
    logic               flush_pend_q, flush_pend_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               flush_done_q, flush_done_d;
    logic [31:0]        bytes_out_q, bytes_out_d;
    logic               run_overflow_q, run_overflow_d;

    logic accept;
    logic xfer;

    assign in_ready     = (state_q == IDLE) && !flush_pend_q;
    assign accept       = in_valid && in_ready;
    assign xfer         = out_valid_q && out_ready;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign flush_done   = flush_done_q;
    assign bytes_out    = bytes_out_q;
    assign run_overflow = run_overflow_q;

    always_comb begin
        state_d        = state_q;
        cache_d        = cache_q;
        have_cache_d   = have_cache_q;
        pend_cnt_d     = pend_cnt_q;
        carry_d        = carry_q;
        next_cache_d   = next_cache_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        flush_done_d   = 1'b0;
        bytes_out_d    = bytes_out_q + {31'd0, xfer};
        run_overflow_d = run_overflow_q;
        flush_pend_d   = ((state_q == DONE) ? 1'b0 : flush_pend_q) | flush;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_byte == 8'hFF && !in_carry) begin
                        if (pend_cnt_q == PEND_MAX) run_overflow_d = 1'b1;
                        else                        pend_cnt_d     = pend_cnt_q + PEND_ONE;
                    end else begin
                        carry_d      = in_carry;
                        next_cache_d = in_byte;
                        if (have_cache_q) begin
                            state_d     = EMIT_CACHE;
                            out_valid_d = 1'b1;
                            out_data_d  = add_carry(cache_q, in_carry);
                        end else if (pend_cnt_q != '0) begin
                            state_d     = EMIT_RUN;
                            out_valid_d = 1'b1;
                            out_data_d  = run_byte(in_carry);
                        end else begin
                            cache_d      = in_byte;
                            have_cache_d = 1'b1;
                        end
                    end
                end else if (flush_pend_q) begin
                    if (have_cache_q) begin
                        state_d     = FLUSH_CACHE;
                        out_valid_d = 1'b1;
                        out_data_d  = cache_q;
                    end else if (pend_cnt_q != '0) begin
                        state_d     = FLUSH_RUN;
                        out_valid_d = 1'b1;
                        out_data_d  = 8'hFF;
                    end else begin
                        state_d      = DONE;
                        flush_done_d = 1'b1;
                    end
                end
            end
            EMIT_CACHE: begin
                if (xfer) begin
                    if (pend_cnt_q != '0) begin
                        state_d    = EMIT_RUN;
                        out_data_d = run_byte(carry_q);
                    end else begin
                        state_d      = IDLE;
                        out_valid_d  = 1'b0;
                        cache_d      = next_cache_q;
                        have_cache_d = 1'b1;
                    end
                end
            end
            EMIT_RUN: begin
                if (xfer) begin
                    pend_cnt_d = pend_cnt_q - PEND_ONE;
                    if (pend_cnt_q == PEND_ONE) begin
                        state_d      = IDLE;
                        out_valid_d  = 1'b0;
                        cache_d      = next_cache_q;
                        have_cache_d = 1'b1;
                    end
                end
            end
            FLUSH_CACHE: begin
                if (xfer) begin
                    have_cache_d = 1'b0;
                    if (pend_cnt_q != '0) begin
                        state_d    = FLUSH_RUN;
                        out_data_d = 8'hFF;
                    end else begin
                        state_d      = DONE;
                        out_valid_d  = 1'b0;
                        flush_done_d = 1'b1;
                    end
                end
            end
            FLUSH_RUN: begin
                if (xfer) begin
                    pend_cnt_d = pend_cnt_q - PEND_ONE;
                    if (pend_cnt_q == PEND_ONE) begin
                        state_d      = DONE;
                        out_valid_d  = 1'b0;
                        flush_done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d      = IDLE;
                cache_d      = 8'h00;
                have_cache_d = INIT_CACHE_VALID;
                pend_cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cache_q        <= 8'h00;
            have_cache_q   <= INIT_CACHE_VALID;
            pend_cnt_q     <= '0;
            carry_q        <= 1'b0;
            next_cache_q   <= 8'h00;
            flush_pend_q   <= 1'b0;
            out_data_q     <= 8'h00;
            out_valid_q    <= 1'b0;
            flush_done_q   <= 1'b0;
            bytes_out_q    <= 32'd0;
            run_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cache_q        <= cache_d;
            have_cache_q   <= have_cache_d;
            pend_cnt_q     <= pend_cnt_d;
            carry_q        <= carry_d;
            next_cache_q   <= next_cache_d;
            flush_pend_q   <= flush_pend_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            flush_done_q   <= flush_done_d;
            bytes_out_q    <= bytes_out_d;
            run_overflow_q <= run_overflow_d;
        end
    end

endmodule

// File: tb/tb_lzma2_rc_carry_resolver.sv
// Directed bench for the LZMA carry resolver: default instance plus a PEND_W=2 instance sharing inputs.
module tb_lzma2_rc_carry_resolver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_carry = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, flush_done, run_overflow;
    logic [7:0]  out_data;
    logic [31:0] bytes_out;
    logic        in_ready2, out_valid2, flush_done2, run_overflow2;
    logic [7:0]  out_data2;
    logic [31:0] bytes_out2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] got_q[$];

    lzma2_rc_carry_resolver dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_carry(in_carry),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush_done(flush_done), .bytes_out(bytes_out), .run_overflow(run_overflow)
    );

    lzma2_rc_carry_resolver #(.PEND_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_carry(in_carry),
        .in_valid(in_valid), .in_ready(in_ready2), .flush(flush),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .flush_done(flush_done2), .bytes_out(bytes_out2), .run_overflow(run_overflow2)
    );

    always #5 clk = ~clk;

    // Output monitor: records transfers, checks stall stability, exclusivity and the cache invariant.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h",
                             out_valid, out_data, prev_data);
                end
            end
            n_checks++;
            if (out_valid && in_ready) begin
                n_fail++;
                $display("FAIL ready_excl: in_ready=%b with out_valid=1, required 0", in_ready);
            end
            n_checks++;
            if (dut.cache_q === 8'hFF) begin
                n_fail++;
                $display("FAIL cache_invariant: cache=%h required not FF", dut.cache_q);
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack_q();
        logic [63:0] r = 64'd0;
        foreach (got_q[i]) r = {r[55:0], got_q[i]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic c);
        int k = 0;
        while (!in_ready && k < 100) begin tick(); k++; end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_wait: in_ready=%b required 1", in_ready);
        end
        in_byte = b; in_carry = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!in_ready && k < 100) begin tick(); k++; end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL idle_wait: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        got_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({in_ready, out_valid, out_data, flush_done, run_overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h done=%b ovf=%b required 1 0 00 0 0",
                     in_ready, out_valid, out_data, flush_done, run_overflow);
        end
        n_checks++;
        if (bytes_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bytes_out: got %0d required 0", bytes_out);
        end
        n_checks++;
        if (dut.have_cache_q !== 1'b1 || dut.cache_q !== 8'h00 || dut.pend_cnt_q !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: have=%b cache=%h pend=%0d required 1 00 0",
                     dut.have_cache_q, dut.cache_q, dut.pend_cnt_q);
        end
    endtask

    task automatic test_basic_flush();
        int k = 0;
        do_reset();
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        while (!flush_done && k < 100) begin tick(); k++; end
        n_checks++;
        if (flush_done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_flush_done: got %b required 1", flush_done);
        end
        tick();
        n_checks++;
        if (flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flush_pulse: flush_done=%b one cycle later, required 0", flush_done);
        end
        n_checks++;
        if (got_q.size() !== 3 || pack_q() !== 64'h1234) begin
            n_fail++;
            $display("FAIL basic_flush_bytes: n=%0d bytes=%h required n=3 bytes=001234", got_q.size(), pack_q());
        end
        n_checks++;
        if (bytes_out !== 32'd3) begin
            n_fail++;
            $display("FAIL basic_bytes_out: got %0d required 3", bytes_out);
        end
    endtask

    task automatic test_carry_run();
        do_reset();
        send(8'h40, 1'b0);
        repeat (3) send(8'hFF, 1'b0);
        send(8'h05, 1'b1);
        wait_idle();
        repeat (10) tick();
        n_checks++;
        if (got_q.size() !== 5 || pack_q() !== 64'h41000000) begin
            n_fail++;
            $display("FAIL carry_run_bytes: n=%0d bytes=%h required n=5 bytes=0041000000", got_q.size(), pack_q());
        end
        n_checks++;
        if (dut.cache_q !== 8'h05 || dut.have_cache_q !== 1'b1 || dut.pend_cnt_q !== 16'd0) begin
            n_fail++;
            $display("FAIL carry_run_state: cache=%h have=%b pend=%0d required 05 1 0",
                     dut.cache_q, dut.have_cache_q, dut.pend_cnt_q);
        end
        n_checks++;
        if (bytes_out !== 32'd5) begin
            n_fail++;
            $display("FAIL carry_run_count: got %0d required 5", bytes_out);
        end
    endtask

    task automatic test_no_carry_run();
        do_reset();
        send(8'h40, 1'b0);
        repeat (2) send(8'hFF, 1'b0);
        send(8'h07, 1'b0);
        wait_idle();
        tick();
        n_checks++;
        if (got_q.size() !== 4 || pack_q() !== 64'h0040FFFF) begin
            n_fail++;
            $display("FAIL nocarry_bytes: n=%0d bytes=%h required n=4 bytes=0040FFFF", got_q.size(), pack_q());
        end
        n_checks++;
        if (dut.pend_cnt_q !== 16'd0 || dut.cache_q !== 8'h07) begin
            n_fail++;
            $display("FAIL nocarry_state: pend=%0d cache=%h required 0 07", dut.pend_cnt_q, dut.cache_q);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fork
            begin
                send(8'h40, 1'b0);
                repeat (2) send(8'hFF, 1'b0);
                send(8'h07, 1'b0);
            end
            begin
                repeat (40) begin tick(); out_ready = ~out_ready; end
                out_ready = 1'b1;
            end
        join
        wait_idle();
        tick();
        n_checks++;
        if (got_q.size() !== 4 || pack_q() !== 64'h0040FFFF) begin
            n_fail++;
            $display("FAIL backpressure_bytes: n=%0d bytes=%h required n=4 bytes=0040FFFF", got_q.size(), pack_q());
        end
        n_checks++;
        if (bytes_out !== 32'd4) begin
            n_fail++;
            $display("FAIL backpressure_count: got %0d required 4", bytes_out);
        end
    endtask

    task automatic test_flush_with_input();
        int k = 0;
        do_reset();
        send(8'h10, 1'b0);
        wait_idle();
        in_byte = 8'h20; in_carry = 1'b1; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        while (!flush_done && k < 100) begin tick(); k++; end
        n_checks++;
        if (flush_done !== 1'b1) begin
            n_fail++;
            $display("FAIL coincide_done: got %b required 1", flush_done);
        end
        n_checks++;
        if (got_q.size() !== 3 || pack_q() !== 64'h1120) begin
            n_fail++;
            $display("FAIL coincide_bytes: n=%0d bytes=%h required n=3 bytes=001120", got_q.size(), pack_q());
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || dut.have_cache_q !== 1'b1 || dut.cache_q !== 8'h00) begin
            n_fail++;
            $display("FAIL coincide_after: rdy=%b have=%b cache=%h required 1 1 00",
                     in_ready, dut.have_cache_q, dut.cache_q);
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        send(8'h01, 1'b0);
        repeat (4) send(8'hFF, 1'b0);
        tick();
        n_checks++;
        if (dut2.pend_cnt_q !== 2'd3 || run_overflow2 !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate: pend=%0d ovf=%b required 3 1", dut2.pend_cnt_q, run_overflow2);
        end
        n_checks++;
        if (run_overflow !== 1'b0 || dut.pend_cnt_q !== 16'd4) begin
            n_fail++;
            $display("FAIL wide_no_saturate: ovf=%b pend=%0d required 0 4", run_overflow, dut.pend_cnt_q);
        end
        out_ready = 1'b0;
        send(8'h02, 1'b0);
        tick();
        n_checks++;
        if (out_valid2 !== 1'b1 || out_data2 !== 8'h01 || in_ready2 !== 1'b0) begin
            n_fail++;
            $display("FAIL emit_hold: vld=%b data=%h rdy=%b required 1 01 0", out_valid2, out_data2, in_ready2);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid2 !== 1'b0 || bytes_out2 !== 32'd0 || run_overflow2 !== 1'b0 || in_ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: vld=%b bytes=%0d ovf=%b rdy=%b required 0 0 0 1",
                     out_valid2, bytes_out2, run_overflow2, in_ready2);
        end
        n_checks++;
        if (dut2.pend_cnt_q !== 2'd0 || dut2.have_cache_q !== 1'b1 || dut2.cache_q !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state: pend=%0d have=%b cache=%h required 0 1 00",
                     dut2.pend_cnt_q, dut2.have_cache_q, dut2.cache_q);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_flush();
        test_carry_run();
        test_no_carry_run();
        test_backpressure();
        test_flush_with_input();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lzma2_rc_carry_resolver.md
Name: lzma2_rc_carry_resolver

Overview:
- Sits directly downstream of lzma2_range_encoder.
- Consumes the top byte and carry bit shifted out of the encoder's 33-bit low register on each normalization step.
- Resolves delayed carries LZMA-style (one cached byte plus a run of pending 0xFF bytes) and emits final compressed bytes on a valid/ready stream toward the LZMA2 chunk packer.
- Also drains cached and pending bytes on a flush request at end of chunk.

Parameters:
- PEND_W, 16, width of the pending-0xFF run counter; maximum run is 2^PEND_W-1.
- INIT_CACHE_VALID, 1, when 1 the cache starts valid holding 0x00 after reset or flush (LZMA cacheSize=1 convention). When 0 the cache starts empty.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_byte  in  8  low[31:24] shifted out by the range encoder
- in_carry  in  1  low[32] carry at the same shift
- in_valid  in  1  in_byte/in_carry valid
- in_ready  out  1  block accepts input this cycle
- flush  in  1  single-cycle request to drain all held bytes
- out_data  out  8  resolved compressed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- flush_done  out  1  one-cycle pulse when the drain is complete
- bytes_out  out  32  count of bytes accepted downstream; wraps mod 2^32
- run_overflow  out  1  sticky error: pending counter saturated

Behaviour:
- Reset/interface decisions: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - in_ready=1, out_valid=0, out_data=0x00, flush_done=0, bytes_out=0, run_overflow=0.
  - cache=0x00, have_cache=INIT_CACHE_VALID, pend_cnt=0, flush_pend=0, state=IDLE.
- States: IDLE, EMIT_CACHE, EMIT_RUN, FLUSH_CACHE, FLUSH_RUN, DONE.
- Handshake:
  - Input is accepted on in_valid && in_ready.
  - in_ready = (state==IDLE) && !flush_pend.
  - Output transfers on out_valid && out_ready.
  - out_data and out_valid hold stable until the transfer completes.
  - out_valid is 0 in IDLE and DONE.
- Accept in IDLE, with byte b and carry c:
  - Absorb case, b==0xFF && c==0: pend_cnt++ and stay in IDLE. Nothing is emitted.
  - Resolve case, otherwise:
    - Latch c into carry_r and b into next_cache.
    - If have_cache, go to EMIT_CACHE.
    - Else if pend_cnt>0, go to EMIT_RUN.
    - Else load cache=b, have_cache=1, and stay in IDLE.
- EMIT_CACHE:
  - out_data = (cache + carry_r) mod 256.
  - On transfer, go to EMIT_RUN if pend_cnt>0, else to IDLE after loading cache=next_cache, have_cache=1.
- EMIT_RUN:
  - out_data = carry_r ? 0x00 : 0xFF.
  - Each transfer decrements pend_cnt.
  - When the last byte transfers (pend_cnt==1), load the cache from next_cache and return to IDLE.
- Latency: the first resolved byte presents out_valid in the cycle after the accept edge. Bytes then stream at 1 byte/cycle while out_ready=1.
- Flush:
  - A flush pulse in any state sets flush_pend.
  - If flush coincides with an accepted input, the input is processed first.
  - On reaching IDLE with flush_pend set:
    - If have_cache, go to FLUSH_CACHE, which emits cache with no carry.
    - Then FLUSH_RUN emits pend_cnt bytes of 0xFF.
    - Then DONE.
- DONE (one cycle):
  - flush_done=1 and flush_pend cleared.
  - cache=0x00, have_cache=INIT_CACHE_VALID, pend_cnt=0.
  - Return to IDLE.
- A flush with nothing held goes straight to DONE. flush_done still pulses one cycle after the pulse is registered.
- Saturation:
  - If pend_cnt==2^PEND_W-1 and another absorb-case byte is accepted, pend_cnt holds and run_overflow sets.
  - run_overflow is cleared only by reset.
- Carry invariant: cache is never 0xFF by construction, so cache+1 never wraps. The bench asserts this.
- bytes_out increments once per output transfer, including flush bytes.
- Reset mid-stream: all state is discarded immediately and no partial byte is emitted. After reset the block behaves as from power-up.
- out_ready may be held low indefinitely; the block backpressures through in_ready=0 outside IDLE.

Test Plan:
- After reset, accept (0x12,c0), (0x34,c0), then flush → output 0x00, 0x12, 0x34; flush_done pulses; bytes_out=3.
- Accept (0x40,c0), (0xFF,c0)×3, (0x05,c1) → output 0x00, 0x41, 0x00, 0x00, 0x00. The cache now holds 0x05 and nothing further is emitted until the next resolve.
- Accept (0x40,c0), (0xFF,c0)×2, (0x07,c0) → output 0x00, 0x40, 0xFF, 0xFF; pend_cnt returns to 0.
- Case B, with out_ready toggled 1010… → each byte is held stable across stall cycles, no byte is duplicated or lost, and in_ready=0 until the run finishes.
- Flush asserted in the same cycle as an accepted (0x20,c1) while the cache holds 0x10 → input processed first: output 0x11, then the flush emits 0x20, then flush_done.
- With PEND_W=2, accept (0x01,c0) followed by four (0xFF,c0) → pend_cnt saturates at 3 and run_overflow=1. Then assert rst_n=0 mid-EMIT → out_valid=0 immediately and all counters are cleared.
